// File: rtl/stream_pkg.sv
// Purpose: shared helpers for the stream FIFO (count width, pointer width, pointer wrap).
// Latency: n/a, constant functions only.
// Backpressure: n/a.
package stream_pkg;

  // Bits needed to hold the value n (occupancy can reach DEPTH itself).
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to address depth entries; never less than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Advance a ring pointer, wrapping from depth-1 back to 0 (depth need not be a power of two).
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Purpose: handshake/data bundle between a producer/consumer pair and stream_fifo.
// Latency: n/a, wires only.
// Backpressure: ready_out toward the producer, ready_in from the consumer.
// Ports: flush, data_in/valid_in/ready_out (write side),
//        data_out/valid_out/ready_in (read side), count, almost_full (status).
interface stream_fifo_if import stream_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) ();
  localparam int CW = clog2p1(DEPTH);

  logic             flush;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic [CW-1:0]    count;
  logic             almost_full;

  // Environment side: drives writes, read-acceptance and flush.
  modport master (
    output flush, data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, count, almost_full
  );

  // FIFO side.
  modport slave (
    input  flush, data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, count, almost_full
  );
endinterface

// File: rtl/stream_fifo.sv
// Purpose: DEPTH x WIDTH first-word-fall-through valid/ready buffer with occupancy, almost-full and flush.
// Latency: 1 cycle from push to data_out/valid_out; push and pop in the same cycle sustain full rate.
// Backpressure: ready_out = not full, from registered state only (no path from ready_in); full+pop refuses the push.
// Ports: clk, rst (async, active-high), bus (stream_fifo_if.slave, see interface file).
module stream_fifo import stream_pkg::*; #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic         clk,
  input  logic         rst,
  stream_fifo_if.slave bus
);
  localparam int CW = clog2p1(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic push;
  logic pop;
  logic full;
  logic empty;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign push = bus.valid_in && !full;
  assign pop  = !empty && bus.ready_in;

  assign bus.ready_out   = !full;
  assign bus.valid_out   = !empty;
  assign bus.data_out    = mem_q[rd_ptr_q];
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= CW'(AFULL_LVL));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Flush wins over any same-cycle transfer; the offered word is dropped
    // even though the producer sees its handshake complete. Storage keeps
    // stale words, which are unreachable once count is 0.
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.data_in;
        wr_ptr_d        = PW'(next_ptr(int'(wr_ptr_q), DEPTH));
      end
      if (pop) begin
        rd_ptr_d = PW'(next_ptr(int'(rd_ptr_q), DEPTH));
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Purpose: self-checking bench for stream_fifo (DEPTH 4 directed tests, DEPTH 3 random wrap test).
// Latency: inputs driven 1 time unit after the rising edge, everything sampled on the falling edge.
// Backpressure: a queue model per instance decides acceptance from its own occupancy.
module tb_stream_fifo;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  stream_fifo_if #(.WIDTH(16), .DEPTH(4)) if4 ();
  stream_fifo_if #(.WIDTH(16), .DEPTH(3)) if3 ();

  stream_fifo #(.WIDTH(16), .DEPTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  stream_fifo #(.WIDTH(16), .DEPTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q4 [$];
  logic [15:0] q3 [$];
  int pops4   = 0;
  int pushed3 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model + monitor for the DEPTH 4 instance: the queue is the
  // buffer contents; DUT outputs are compared against it before each edge,
  // then the handshakes that will happen at that edge are applied to it.
  always @(negedge clk) begin
    int sz;
    sz = q4.size();
    if (rst) begin
      q4.delete();
      chk("rst4_count", 32'(if4.count), 32'd0);
      chk("rst4_valid", 32'(if4.valid_out), 32'd0);
      chk("rst4_ready", 32'(if4.ready_out), 32'd1);
      chk("rst4_afull", 32'(if4.almost_full), 32'd0);
      chk("rst4_data", 32'(if4.data_out), 32'd0);
    end else begin
      chk("m4_count", 32'(if4.count), 32'(sz));
      chk("m4_valid", 32'(if4.valid_out), 32'(sz != 0));
      chk("m4_ready", 32'(if4.ready_out), 32'(sz != 4));
      chk("m4_afull", 32'(if4.almost_full), 32'(sz >= 3));
      if (sz != 0) chk("m4_data", 32'(if4.data_out), 32'(q4[0]));
      if (if4.flush) begin
        q4.delete();
      end else begin
        if (sz != 0 && if4.ready_in) begin
          void'(q4.pop_front());
          pops4++;
        end
        if (if4.valid_in && sz < 4) q4.push_back(if4.data_in);
      end
    end
  end

  // Same model for the DEPTH 3 instance (almost_full threshold defaults to 2).
  always @(negedge clk) begin
    int sz;
    sz = q3.size();
    if (rst) begin
      q3.delete();
      chk("rst3_count", 32'(if3.count), 32'd0);
      chk("rst3_valid", 32'(if3.valid_out), 32'd0);
    end else begin
      chk("m3_count", 32'(if3.count), 32'(sz));
      chk("m3_count_max", 32'(if3.count <= 2'd3), 32'd1);
      chk("m3_valid", 32'(if3.valid_out), 32'(sz != 0));
      chk("m3_ready", 32'(if3.ready_out), 32'(sz != 3));
      chk("m3_afull", 32'(if3.almost_full), 32'(sz >= 2));
      if (sz != 0) chk("m3_data", 32'(if3.data_out), 32'(q3[0]));
      if (sz != 0 && if3.ready_in) void'(q3.pop_front());
      if (if3.valid_in && sz < 3) begin
        q3.push_back(if3.data_in);
        pushed3++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int cyc;
    rst          = 1'b1;
    if4.flush    = 1'b0;
    if4.valid_in = 1'b0;
    if4.data_in  = '0;
    if4.ready_in = 1'b0;
    if3.flush    = 1'b0;
    if3.valid_in = 1'b0;
    if3.data_in  = '0;
    if3.ready_in = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // Reset then fill with the consumer stalled.
    for (int i = 1; i <= 4; i++) begin
      if4.valid_in = 1'b1;
      if4.data_in  = 16'(i);
      step();
      chk("fill_count", 32'(if4.count), 32'(i));
      chk("fill_afull", 32'(if4.almost_full), 32'(i >= 3));
      chk("fill_ready", 32'(if4.ready_out), 32'(i != 4));
      chk("fill_head", 32'(if4.data_out), 32'h0001);
    end
    if4.valid_in = 1'b0;
    if4.flush    = 1'b1;
    step();
    if4.flush = 1'b0;
    chk("flush_empty", 32'(if4.count), 32'd0);

    // Streaming from empty: 100 words in 101 cycles means no bubbles.
    p0 = pops4;
    if4.valid_in = 1'b1;
    if4.ready_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if4.data_in = 16'h0100 + 16'(i);
      step();
      chk("stream_count", 32'(if4.count), 32'd1);
    end
    if4.valid_in = 1'b0;
    step();
    chk("stream_words", 32'(pops4 - p0), 32'd100);
    chk("stream_drained", 32'(if4.count), 32'd0);

    // Full plus push plus pop: the push is refused, then taken next cycle.
    if4.ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if4.valid_in = 1'b1;
      if4.data_in  = 16'h00A0 + 16'(i);
      step();
    end
    if4.data_in  = 16'h00B0;
    if4.ready_in = 1'b1;
    step();
    chk("fpp_count", 32'(if4.count), 32'd3);
    chk("fpp_head", 32'(if4.data_out), 32'h00A1);
    chk("fpp_ready", 32'(if4.ready_out), 32'd1);
    if4.ready_in = 1'b0;
    step();
    chk("fpp_accept", 32'(if4.count), 32'd4);
    if4.valid_in = 1'b0;
    if4.ready_in = 1'b1;
    repeat (4) step();
    chk("fpp_drained", 32'(if4.count), 32'd0);

    // Flush with three words stored and a word offered in the same cycle.
    if4.ready_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if4.valid_in = 1'b1;
      if4.data_in  = 16'h00D0 + 16'(i);
      step();
    end
    if4.data_in  = 16'h00CC;
    if4.ready_in = 1'b1;
    if4.flush    = 1'b1;
    step();
    chk("flush_count", 32'(if4.count), 32'd0);
    chk("flush_valid", 32'(if4.valid_out), 32'd0);
    if4.flush    = 1'b0;
    if4.valid_in = 1'b0;
    step();
    chk("flush_no_cc", 32'(if4.count), 32'd0);
    chk("flush_no_cc_valid", 32'(if4.valid_out), 32'd0);

    // Asynchronous reset with two words stored.
    if4.ready_in = 1'b0;
    if4.valid_in = 1'b1;
    if4.data_in  = 16'h0011;
    step();
    if4.data_in = 16'h0022;
    step();
    if4.valid_in = 1'b0;
    chk("pre_rst_count", 32'(if4.count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(if4.count), 32'd0);
    chk("arst_valid", 32'(if4.valid_out), 32'd0);
    chk("arst_ready", 32'(if4.ready_out), 32'd1);
    chk("arst_afull", 32'(if4.almost_full), 32'd0);
    chk("arst_data", 32'(if4.data_out), 32'd0);
    step();
    rst          = 1'b0;
    if4.valid_in = 1'b1;
    if4.data_in  = 16'h0055;
    step();
    if4.valid_in = 1'b0;
    chk("post_rst_valid", 32'(if4.valid_out), 32'd1);
    chk("post_rst_data", 32'(if4.data_out), 32'h0055);
    chk("post_rst_count", 32'(if4.count), 32'd1);
    if4.ready_in = 1'b1;
    step();
    if4.ready_in = 1'b0;

    // Random push/pop on the DEPTH 3 instance across many pointer wraps.
    cyc = 0;
    while (pushed3 < 50 && cyc < 2000) begin
      if3.valid_in = ($urandom_range(0, 3) != 0);
      if3.data_in  = 16'($urandom);
      if3.ready_in = ($urandom_range(0, 1) != 0);
      step();
      cyc++;
    end
    chk("wrap_words", 32'(pushed3 >= 50), 32'd1);
    if3.valid_in = 1'b0;
    if3.ready_in = 1'b1;
    repeat (5) step();
    chk("wrap_drained", 32'(if3.count), 32'd0);
    chk("wrap_valid", 32'(if3.valid_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
